// File: rtl/corerfd_pkg.sv
// Shared types and constants for the measurement scheduler.
package corerfd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned NREQ_DFLT = 4;
    localparam int unsigned IDX_W     = (NREQ_DFLT > 1) ? $clog2(NREQ_DFLT) : 1;

endpackage

// File: rtl/corerfd_rr_arb.sv
// Round-robin pick: first asserted request at or above rr_ptr, wrapping modulo NREQ.
module corerfd_rr_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            valid,
    output logic [IW-1:0]   index
);

    logic [IW-1:0] cand;

    // Scan NREQ positions starting at the pointer; keep the first hit.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(rr_ptr) + i) % NREQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/corerfd_meas_sched.sv
// Shares one external sample-window counter among NREQ measurement requesters.
module corerfd_meas_sched
    import corerfd_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned CTR_SIZE = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*CTR_SIZE-1:0] win_len,
    input  logic                     abort,
    input  logic                     timeout,
    output logic                     smpl_en,
    output logic [CTR_SIZE-1:0]      smpl_max,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          done,
    output logic                     zero_err,
    output logic                     busy
);

    localparam int unsigned IW = idx_width(NREQ);

    state_e              state_q, state_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]       own_q, own_d;
    logic [CTR_SIZE-1:0] smpl_max_q, smpl_max_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic                smpl_en_q, smpl_en_d;
    logic                zero_err_q, zero_err_d;
    logic                busy_q, busy_d;

    logic                arb_valid;
    logic [IW-1:0]       arb_idx;
    logic [CTR_SIZE-1:0] sel_len;
    logic                cancel;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] k);
        return (32'(k) == NREQ - 1) ? '0 : k + IW'(1);
    endfunction

    corerfd_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (arb_valid),
        .index  (arb_idx)
    );

    // Window length of the currently selected candidate.
    always_comb begin
        sel_len = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IW'(i) == arb_idx) begin
                sel_len = win_len[i*CTR_SIZE +: CTR_SIZE];
            end
        end
    end

    // Next state, pointer and owner; outputs decoded from the next state so they register with it.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        own_d      = own_q;
        smpl_max_d = smpl_max_q;
        grant_d    = '0;
        done_d     = '0;
        smpl_en_d  = 1'b0;
        zero_err_d = 1'b0;
        cancel     = abort || !req[own_q];

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    if (sel_len == '0) begin
                        zero_err_d = 1'b1;
                        rr_ptr_d   = next_idx(arb_idx);
                    end else begin
                        own_d      = arb_idx;
                        smpl_max_d = sel_len;
                        state_d    = ST_ARM;
                    end
                end
            end
            ST_ARM: begin
                if (cancel) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_idx(own_q);
                end else begin
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // Cancel outranks a coincident timeout.
                if (cancel) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_idx(own_q);
                end else if (timeout) begin
                    state_d  = ST_DONE;
                    rr_ptr_d = next_idx(own_q);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_ARM:  grant_d = NREQ'(1) << own_d;
            ST_RUN: begin
                grant_d   = NREQ'(1) << own_d;
                smpl_en_d = 1'b1;
            end
            ST_DONE: done_d = NREQ'(1) << own_d;
            default: ;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            own_q      <= '0;
            smpl_max_q <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            smpl_en_q  <= 1'b0;
            zero_err_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            own_q      <= own_d;
            smpl_max_q <= smpl_max_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            smpl_en_q  <= smpl_en_d;
            zero_err_q <= zero_err_d;
            busy_q     <= busy_d;
        end
    end

    assign smpl_en  = smpl_en_q;
    assign smpl_max = smpl_max_q;
    assign grant    = grant_q;
    assign done     = done_q;
    assign zero_err = zero_err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_corerfd_meas_sched.sv
// Directed bench for corerfd_meas_sched with a per-cycle reference model.
module tb_corerfd_meas_sched;

    localparam int N = 4;
    localparam int C = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req;
    logic [N*C-1:0] win_len;
    logic           abort;
    logic           timeout;
    logic           smpl_en;
    logic [C-1:0]   smpl_max;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           zero_err;
    logic           busy;

    logic to_force, to_auto, auto_en;
    int   cnt;
    int   n_vec  = 0;
    int   n_miss = 0;

    assign timeout = to_force | to_auto;

    always #5 clk = ~clk;

    corerfd_meas_sched #(.NREQ(N), .CTR_SIZE(C)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .win_len  (win_len),
        .abort    (abort),
        .timeout  (timeout),
        .smpl_en  (smpl_en),
        .smpl_max (smpl_max),
        .grant    (grant),
        .done     (done),
        .zero_err (zero_err),
        .busy     (busy)
    );

    // External sample counter: timeout once smpl_max enabled cycles have been seen.
    always @(negedge clk) begin
        if (smpl_en) cnt = cnt + 1;
        else         cnt = 0;
        to_auto = auto_en && smpl_en && (cnt == int'(smpl_max));
    end

    // Reference model: phase 0 idle, 1 arming, 2 running, 3 done.
    int           m_ph, m_own, m_ptr, m_k;
    logic [C-1:0] m_max;
    logic         m_zerr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = 0; m_own = 0; m_ptr = 0; m_max = '0; m_zerr = 1'b0;
        end else begin
            m_zerr = 1'b0;
            case (m_ph)
                0: begin
                    m_k = -1;
                    for (int i = 0; i < N; i++)
                        if (m_k < 0 && req[(m_ptr + i) % N]) m_k = (m_ptr + i) % N;
                    if (m_k >= 0) begin
                        if (win_len[m_k*C +: C] == '0) begin
                            m_zerr = 1'b1;
                            m_ptr  = (m_k + 1) % N;
                        end else begin
                            m_own = m_k;
                            m_max = win_len[m_k*C +: C];
                            m_ph  = 1;
                        end
                    end
                end
                1, 2: begin
                    if (abort || !req[m_own]) begin
                        m_ph = 0; m_ptr = (m_own + 1) % N;
                    end else if (m_ph == 1) begin
                        m_ph = 2;
                    end else if (timeout) begin
                        m_ph = 3; m_ptr = (m_own + 1) % N;
                    end
                end
                default: m_ph = 0;
            endcase
        end
    end

    logic [N-1:0] e_grant, e_done;
    logic         e_en, e_busy;

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst) begin
            e_grant = (m_ph == 1 || m_ph == 2) ? (N'(1) << m_own) : '0;
            e_done  = (m_ph == 3) ? (N'(1) << m_own) : '0;
            e_en    = (m_ph == 2);
            e_busy  = (m_ph != 0);
            n_vec++;
            if (grant !== e_grant || done !== e_done || smpl_en !== e_en ||
                smpl_max !== m_max || zero_err !== m_zerr || busy !== e_busy ||
                !$onehot0(grant) || !$onehot0(done)) begin
                n_miss++;
                $display("FAIL cycle@%0t got/exp grant=%b/%b done=%b/%b en=%b/%b max=%0d/%0d zerr=%b/%b busy=%b/%b",
                         $time, grant, e_grant, done, e_done, smpl_en, e_en,
                         smpl_max, m_max, zero_err, m_zerr, busy, e_busy);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_len(input int i, input int v);
        win_len[i*C +: C] = C'(v);
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Wait for grant (sel 0) or smpl_en (sel 1) with a cycle budget.
    task automatic wait_for(input string nm, input int sel, input int budget);
        for (int c = 0; c < budget; c++) begin
            step();
            if ((sel == 0 && grant != '0) || (sel == 1 && smpl_en)) return;
        end
        n_vec++;
        n_miss++;
        $display("FAIL %s: no event within %0d cycles", nm, budget);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    int lat_g, lat_e, lat_d, nd, g_first, max_seen, ng, dbl, nz, ngr;
    int order[5];
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] prev_grant, prev_done;

    initial begin
        req = '0; win_len = '0; abort = 1'b0; to_force = 1'b0; to_auto = 1'b0;
        auto_en = 1'b1; cnt = 0;

        // Reset state
        step();
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_max", int'(smpl_max), 0);
        step();
        rst = 1'b0;

        // Single request, length 5, with a win_len change while busy
        set_len(0, 5);
        req = 4'b0001;
        lat_g = -1; lat_e = -1; lat_d = -1; nd = 0; g_first = 0; max_seen = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 4) set_len(0, 9);
            if (grant != '0 && lat_g < 0) begin
                lat_g = c; g_first = int'(grant); max_seen = int'(smpl_max);
            end
            if (smpl_en && lat_e < 0) lat_e = c;
            if (done != '0) begin
                if (lat_d < 0) lat_d = c;
                nd++;
                req = '0;
            end
        end
        chk("t1_grant_lat", lat_g, 1);
        chk("t1_en_lat", lat_e, 2);
        chk("t1_done_lat", lat_d, 7);
        chk("t1_grant", g_first, 1);
        chk("t1_max", max_seen, 5);
        chk("t1_done_cnt", nd, 1);
        chk("t1_busy_after", int'(busy), 0);

        // Fairness with all four requesting
        do_reset();
        for (int i = 0; i < N; i++) set_len(i, 3);
        req = 4'b1111;
        ng = 0; nd = 0; dbl = 0; prev_grant = '0; prev_done = '0;
        for (int i = 0; i < 5; i++) order[i] = -1;
        for (int c = 0; c < 200 && nd < 5; c++) begin
            step();
            if (grant != '0 && prev_grant == '0 && ng < 5) begin
                order[ng] = idx_of(grant); ng++;
            end
            if (done != '0) begin
                nd++;
                if (prev_done != '0) dbl++;
                if (nd == 5) req = '0;
            end
            prev_grant = grant;
            prev_done  = done;
        end
        step();
        chk("t2_done_cnt", nd, 5);
        chk("t2_done_width", dbl, 0);
        for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), order[i], exp_ord[i]);

        // Zero-length request
        do_reset();
        set_len(2, 0);
        req = 4'b0100;
        nz = 0; ngr = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            req = '0;
            if (zero_err) nz++;
            if (grant != '0) ngr++;
        end
        chk("t3_zerr_cnt", nz, 1);
        chk("t3_no_grant", ngr, 0);
        req = 4'b1111;
        wait_for("t3_grant", 0, 10);
        chk("t3_next_idx", idx_of(grant), 3);
        req = '0;
        step(); step();

        // Cancel race: abort with timeout while running
        auto_en = 1'b0;
        set_len(1, 4);
        req = 4'b0010;
        wait_for("t4_run", 1, 10);
        step();
        req = 4'b0011;
        set_len(1, 7);
        step();
        chk("t4_grant_hold", int'(grant), 2);
        chk("t4_max_hold", int'(smpl_max), 4);
        abort = 1'b1;
        to_force = 1'b1;
        step();
        chk("t4_done", int'(done), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_grant", int'(grant), 0);
        abort = 1'b0; to_force = 1'b0; req = '0;
        nd = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (done != '0) nd++;
        end
        chk("t4_no_done", nd, 0);
        set_len(0, 3);
        req = 4'b0011;
        wait_for("t4_regrant", 0, 10);
        chk("t4_ptr_adv", idx_of(grant), 0);
        req = '0;
        step(); step();

        // Stray timeout in IDLE and ARM; abort in IDLE does not block
        to_force = 1'b1;
        step();
        to_force = 1'b0;
        chk("t5_idle_busy", int'(busy), 0);
        chk("t5_idle_done", int'(done), 0);
        abort = 1'b1;
        req = 4'b0001;
        step();
        abort = 1'b0;
        chk("t5_abort_idle", int'(grant), 1);
        to_force = 1'b1;
        step();
        to_force = 1'b0;
        chk("t5_arm_to_run", int'(smpl_en), 1);
        chk("t5_arm_done", int'(done), 0);
        step();
        chk("t5_still_busy", int'(busy), 1);
        req = '0;
        step(); step();

        // Reset in the middle of a window
        set_len(1, 6);
        req = 4'b0010;
        wait_for("t6_run", 1, 10);
        step();
        chk("t6_grant_pre", int'(grant), 2);
        rst = 1'b1;
        #1;
        chk("t6_rst_grant", int'(grant), 0);
        chk("t6_rst_en", int'(smpl_en), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_max", int'(smpl_max), 0);
        chk("t6_rst_done", int'(done | N'(zero_err)), 0);
        step();
        for (int i = 0; i < N; i++) set_len(i, 2);
        req = 4'b1111;
        step();
        rst = 1'b0;
        wait_for("t6_grant", 0, 10);
        chk("t6_first_grant", int'(grant), 1);
        req = '0;
        step(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
